mdu: RTL

Multiply/divide unit serving the execute stage's MDU request port. It performs single-cycle MULT/MULTU and MTHI/MTLO writes, and iterative 32-step DIV/DIVU. It owns the architectural HI/LO registers and reports `mdu_is_active` and `mdu_div_active` back to execute, which uses them to hold dependent instructions.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/div_iter.sv | 78 +++++++
 rtl/mdu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, HI/LO payload.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled with `define MDU_MADD_EN.
package mdu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

`ifdef MDU_MADD_EN
  localparam int unsigned MDOP_W = 10;
`else
  localparam int unsigned MDOP_W = 6;
`endif

  localparam int unsigned MD_MULT  = 0;
  localparam int unsigned MD_MULTU = 1;
  localparam int unsigned MD_DIV   = 2;
  localparam int unsigned MD_DIVU  = 3;
  localparam int unsigned MD_MTHI  = 4;
  localparam int unsigned MD_MTLO  = 5;
  localparam int unsigned MD_MADD  = 6;
  localparam int unsigned MD_MADDU = 7;
  localparam int unsigned MD_MSUB  = 8;
  localparam int unsigned MD_MSUBU = 9;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_DIV  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Magnitude of v when treated as signed (sgn=1), otherwise v unchanged.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn & v[XLEN-1]) ? ((~v) + XLEN'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// 32-step unsigned restoring divider core: one quotient bit per cycle after start_i.
// done_c flags the cycle in which the final step is taken.
module div_iter
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            cancel_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_c
);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    diff;
  logic             fit;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    fit    = ~diff[XLEN];
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (cancel_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dsr_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = fit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], fit};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(XLEN - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_c = busy_q & ~cancel_i & (cnt_q == CNT_W'(XLEN - 1));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: single-cycle MULT/MULTU/MTHI/MTLO, iterative DIV/DIVU, owns HI/LO.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only with `define MDU_MADD_EN.
module mdu
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_flush_i,
  input  logic              ex_stall_i,
  input  logic              mdu_cancel_i,
  input  logic [MDOP_W-1:0] ex_mduop_i,
  input  logic [XLEN-1:0]   ex_mdu_opr1_i,
  input  logic [XLEN-1:0]   ex_mdu_opr2_i,
  input  logic [XLEN-1:0]   ex_mdu_whi_i,
  input  logic [XLEN-1:0]   ex_mdu_wlo_i,
  output logic [XLEN-1:0]   mdu_hi_o,
  output logic [XLEN-1:0]   mdu_lo_o,
  output logic              mdu_is_active,
  output logic              mdu_div_active
);

  mdu_state_e        state_q, state_d;
  hilo_t             hilo_q, hilo_d;
  logic              active_q, active_d;
  logic              neg_quo_q, neg_rem_q, divz_q;

  logic              issue_c, go_c, start_c, is_div_c, div_sgn_c, divz_c;
  logic              mul_sgn_c, div_cancel_c, div_done_c;
  logic [XLEN-1:0]   dividend_c, divisor_c;
  logic [XLEN-1:0]   quo_c, rem_c;
  logic [2*XLEN-1:0] mul_a_c, mul_b_c, prod_c;

  assign issue_c   = (|ex_mduop_i) & ~ex_stall_i & ~ex_flush_i;
  assign go_c      = issue_c & (state_q == MDU_IDLE);
  assign is_div_c  = ex_mduop_i[MD_DIV] | ex_mduop_i[MD_DIVU];
  assign div_sgn_c = ex_mduop_i[MD_DIV];
  assign start_c   = go_c & is_div_c;
  assign divz_c    = ~|ex_mdu_opr2_i;

  // A zero divisor runs the raw dividend unsigned: the core then yields Q=all-ones, R=opr1.
  assign dividend_c = divz_c ? ex_mdu_opr1_i : abs_val(ex_mdu_opr1_i, div_sgn_c);
  assign divisor_c  = abs_val(ex_mdu_opr2_i, div_sgn_c);

`ifdef MDU_MADD_EN
  assign mul_sgn_c = ex_mduop_i[MD_MULT] | ex_mduop_i[MD_MADD] | ex_mduop_i[MD_MSUB];
`else
  assign mul_sgn_c = ex_mduop_i[MD_MULT];
`endif

  // Low 64 bits of the product of extended operands equal the signed/unsigned 64-bit product.
  assign mul_a_c = {{XLEN{mul_sgn_c & ex_mdu_opr1_i[XLEN-1]}}, ex_mdu_opr1_i};
  assign mul_b_c = {{XLEN{mul_sgn_c & ex_mdu_opr2_i[XLEN-1]}}, ex_mdu_opr2_i};
  assign prod_c  = mul_a_c * mul_b_c;

  assign div_cancel_c = mdu_cancel_i & (state_q != MDU_IDLE);

  div_iter u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_c),
    .cancel_i   (div_cancel_c),
    .dividend_i (dividend_c),
    .divisor_i  (divisor_c),
    .quo_o      (quo_c),
    .rem_o      (rem_c),
    .done_c     (div_done_c)
  );

  always_comb begin
    state_d  = state_q;
    hilo_d   = hilo_q;
    active_d = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (go_c) begin
          if (is_div_c) begin
            state_d = MDU_DIV;
          end
          if (ex_mduop_i[MD_MULT] | ex_mduop_i[MD_MULTU]) begin
            hilo_d = hilo_t'(prod_c);
          end
          if (ex_mduop_i[MD_MTHI]) begin
            hilo_d.hi = ex_mdu_whi_i;
          end
          if (ex_mduop_i[MD_MTLO]) begin
            hilo_d.lo = ex_mdu_wlo_i;
          end
`ifdef MDU_MADD_EN
          if (ex_mduop_i[MD_MADD] | ex_mduop_i[MD_MADDU]) begin
            hilo_d = hilo_t'(hilo_q + prod_c);
          end
          if (ex_mduop_i[MD_MSUB] | ex_mduop_i[MD_MSUBU]) begin
            hilo_d = hilo_t'(hilo_q - prod_c);
          end
`endif
        end
      end
      MDU_DIV: begin
        if (mdu_cancel_i) begin
          state_d = MDU_IDLE;
        end else if (div_done_c) begin
          state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        state_d = MDU_IDLE;
        if (!mdu_cancel_i) begin
          hilo_d.lo = neg_if(quo_c, neg_quo_q & ~divz_q);
          hilo_d.hi = neg_if(rem_c, neg_rem_q & ~divz_q);
        end
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase
    active_d = (state_d != MDU_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      hilo_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hilo_q   <= hilo_d;
      active_q <= active_d;
    end
  end

  // Result sign fix-up flags, captured once at division start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
    end else if (start_c) begin
      neg_quo_q <= div_sgn_c & (ex_mdu_opr1_i[XLEN-1] ^ ex_mdu_opr2_i[XLEN-1]);
      neg_rem_q <= div_sgn_c & ex_mdu_opr1_i[XLEN-1];
      divz_q    <= divz_c;
    end
  end

  assign mdu_hi_o       = hilo_q.hi;
  assign mdu_lo_o       = hilo_q.lo;
  assign mdu_div_active = active_q;
  assign mdu_is_active  = active_q;

endmodule
